// File: rtl/lcd_frame_sequencer_pkg.sv
// rtl/lcd_frame_sequencer_pkg.sv - shared types and constants for the LCD frame sequencer
package lcd_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LINE_CMD = 3'd1,
    ST_SEL_WAIT = 3'd2,
    ST_CHAR_OUT = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

  localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;

  function automatic int frame_chars(input int line_len, input int num_lines);
    return line_len * num_lines;
  endfunction

  // DDRAM set-address command for the start of a display line
  function automatic logic [7:0] line_cmd(input int line);
    return (line == 0) ? LCD_CMD_LINE0 : LCD_CMD_LINE1;
  endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// rtl/lcd_frame_sequencer_if.sv - lookup and LCD-driver handshake bundle for the sequencer
interface lcd_frame_sequencer_if #(
  parameter int SEL_W = 6
);
  logic             start;
  logic [SEL_W-1:0] sel;
  logic [7:0]       lookup_data;
  logic             lookup_ready;
  logic [7:0]       lcd_data;
  logic             lcd_rs;
  logic             lcd_valid;
  logic             lcd_ready;
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, lookup_data, lookup_ready, lcd_ready,
    output sel, lcd_data, lcd_rs, lcd_valid, busy, frame_done
  );

  modport slave (
    output start, lookup_data, lookup_ready, lcd_ready,
    input  sel, lcd_data, lcd_rs, lcd_valid, busy, frame_done
  );
endinterface

// File: rtl/lcd_frame_sequencer_refresh_timer.sv
// rtl/lcd_frame_sequencer_refresh_timer.sv - free-running auto-refresh tick generator
module lcd_refresh_timer #(
  parameter int REFRESH_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);
  localparam bit EN    = (REFRESH_CYCLES > 0);
  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EN ? REFRESH_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  // Period 0 parks the counter at zero and never ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!EN || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = EN && (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - sweeps lookup cells and streams LCD address commands and characters
module lcd_frame_sequencer
  import lcd_frame_sequencer_pkg::*;
#(
  parameter int SEL_W          = 6,
  parameter int LINE_LEN       = 16,
  parameter int NUM_LINES      = 2,
  parameter int LOOKUP_LAT     = 2,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_frame_sequencer_if.master bus
);
  localparam int FRAME_CHARS = frame_chars(LINE_LEN, NUM_LINES);
  localparam int COL_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int LAT_W  = $clog2(LOOKUP_LAT + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(LOOKUP_LAT);

  seq_state_e        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [7:0]        lcd_data_q;
  logic              lcd_rs_q;
  logic              lcd_valid_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              pending_q;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] line_q;
  logic [LAT_W-1:0]  lat_q;

  logic              tick;
  logic              req_d;
  logic              launch_d;
  logic [SEL_W-1:0]  line_base_d;

  lcd_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // A refresh tick is indistinguishable from an external start request
  assign req_d       = bus.start || tick;
  assign launch_d    = req_d || pending_q;
  assign line_base_d = SEL_W'(int'(line_q) * LINE_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      lcd_data_q   <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      lat_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        // DONE relaunches directly so a queued frame starts the very next cycle
        ST_IDLE, ST_DONE: begin
          if (launch_d) begin
            state_q     <= ST_LINE_CMD;
            busy_q      <= 1'b1;
            pending_q   <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            sel_q       <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= line_cmd(0);
            lcd_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_LINE_CMD: begin
          if (req_d) pending_q <= 1'b1;
          if (bus.lcd_ready) begin
            lcd_valid_q <= 1'b0;
            sel_q       <= line_base_d;
            lat_q       <= '0;
            state_q     <= ST_SEL_WAIT;
          end
        end

        // lat_q counts cycles since sel moved; data is trusted once it saturates
        ST_SEL_WAIT: begin
          if (req_d) pending_q <= 1'b1;
          if (lat_q != LAT_MAX) begin
            lat_q <= lat_q + 1'b1;
          end else if (bus.lookup_ready) begin
            lcd_data_q  <= bus.lookup_data;
            lcd_rs_q    <= 1'b1;
            lcd_valid_q <= 1'b1;
            state_q     <= ST_CHAR_OUT;
          end
        end

        ST_CHAR_OUT: begin
          if (req_d) pending_q <= 1'b1;
          if (bus.lcd_ready) begin
            lcd_valid_q <= 1'b0;
            if (col_q != COL_LAST) begin
              col_q   <= col_q + 1'b1;
              sel_q   <= sel_q + 1'b1;
              lat_q   <= '0;
              state_q <= ST_SEL_WAIT;
            end else if (line_q != LINE_LAST) begin
              col_q       <= '0;
              line_q      <= line_q + 1'b1;
              lcd_rs_q    <= 1'b0;
              lcd_data_q  <= line_cmd(int'(line_q) + 1);
              lcd_valid_q <= 1'b1;
              state_q     <= ST_LINE_CMD;
            end else begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              sel_q        <= '0;
              state_q      <= ST_DONE;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          lcd_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_valid  = lcd_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

  // The sweep index must stay inside the select range for any parameter set
  initial assert (FRAME_CHARS <= (1 << SEL_W));

endmodule
